// File: rtl/timer_pkg.sv
// Shared constants and state encoding for the BCD countdown timer.
// Quick-add constants are consumed only when TIMER_ADD30_EN is defined.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] MAX_MOD10 = 4'd9;
  localparam logic [3:0] MAX_MOD6  = 4'd5;

  localparam int         ADD30_DIGIT = 1;
  localparam logic [3:0] ADD30_INC   = 4'd3;

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Command/status bundle between the controller and the countdown timer.
// The add30 signal is present only when TIMER_ADD30_EN is defined.
interface bcd_countdown_timer_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    tick;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic                    start;
  logic                    stop;
`ifdef TIMER_ADD30_EN
  logic                    add30;
`endif
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic                    running;
  logic                    zero;
  logic                    done;

`ifdef TIMER_ADD30_EN
  modport master (
    output tick, load, load_value,
    output start, stop, add30,
    input  bcd_out, running, zero, done
  );

  modport slave (
    input  tick, load, load_value,
    input  start, stop, add30,
    output bcd_out, running, zero, done
  );
`else
  modport master (
    output tick, load, load_value,
    output start, stop,
    input  bcd_out, running, zero, done
  );

  modport slave (
    input  tick, load, load_value,
    input  start, stop,
    output bcd_out, running, zero, done
  );
`endif

endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit register: clamped load, borrow-chain decrement and,
// with TIMER_ADD30_EN, carry-chain increment plus saturation.
module bcd_digit_cell
  import timer_pkg::*;
#(
  parameter bit IS_MOD6 = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       borrow_in,
  output logic       borrow_out,
`ifdef TIMER_ADD30_EN
  input  logic       inc,
  input  logic       sat,
  input  logic [3:0] inc_amt,
  input  logic       carry_in,
  output logic       carry_out,
`endif
  output logic [3:0] q,
  output logic       digit_zero
);

  localparam logic [3:0] MAX = IS_MOD6 ? MAX_MOD6 : MAX_MOD10;

  logic [3:0] clamped;
  logic [3:0] dec_q;

  assign clamped    = (load_digit > MAX) ? MAX : load_digit;
  assign digit_zero = (q == 4'd0);
  assign dec_q      = digit_zero ? MAX : q - 4'd1;
  assign borrow_out = borrow_in & digit_zero;

`ifdef TIMER_ADD30_EN
  logic [4:0] sum;
  logic [4:0] wrap;
  logic [3:0] inc_q;

  // Sum never exceeds 12, so a single wrap suffices.
  assign sum       = {1'b0, q} + {1'b0, inc_amt} + {4'd0, carry_in};
  assign carry_out = (sum > {1'b0, MAX});
  assign wrap      = sum - {1'b0, MAX} - 5'd1;
  assign inc_q     = carry_out ? wrap[3:0] : sum[3:0];
`endif

  always_ff @(posedge clk) begin
    if (clr)
      q <= 4'd0;
    else if (load)
      q <= clamped;
`ifdef TIMER_ADD30_EN
    else if (sat)
      q <= MAX;
    else if (inc)
      q <= inc_q;
`endif
    else if (borrow_in)
      q <= dec_q;
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with run/pause/done control.
// Define TIMER_ADD30_EN to enable the +30 s quick-add command.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int                    NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS-1:0] MOD6_MASK  = 4'b0010
) (
  input  logic                clk,
  input  logic                clear,
  bcd_countdown_timer_if.slave bus
);

  localparam int W = 4 * NUM_DIGITS;

  state_t                state;
  state_t                nstate;
  logic                  done_q;
  logic                  ndone;
  logic                  c_clr;
  logic                  c_ld;
  logic                  c_dec;
  logic [W-1:0]          c_ldv;
  logic [NUM_DIGITS-1:0] dz;
  logic [W-1:0]          value;
  logic [NUM_DIGITS:0]   borrow;
  logic                  unused_borrow;
  logic                  run_st;
  logic                  is_zero;
  logic                  to_zero;
  logic                  taken;
  logic                  p_clr;
  logic                  p_ld;
  logic                  p_stop;
  logic                  p_start;
  logic                  p_tick;

  assign run_st  = (state == RUN);
  assign is_zero = &dz;
  assign to_zero = (&dz[NUM_DIGITS-1:1]) && (value[3:0] == 4'd1);

`ifdef TIMER_ADD30_EN
  localparam logic [W-1:0] QS_VAL =
    {{(W-4){1'b0}}, ADD30_INC} << (4 * ADD30_DIGIT);

  logic                p_add;
  logic                c_inc;
  logic                c_sat;
  logic [NUM_DIGITS:0] carry;

  assign carry[0] = 1'b0;
  assign c_sat    = c_inc & carry[NUM_DIGITS];
`endif

  // Mask lower-priority commands so exactly one decode term fires.
  assign p_clr = clear;
  assign p_ld  = ~p_clr & bus.load;
`ifdef TIMER_ADD30_EN
  assign p_add = ~p_clr & ~p_ld & bus.add30;
  assign taken = p_clr | p_ld | p_add;
`else
  assign taken = p_clr | p_ld;
`endif
  assign p_stop  = ~taken & bus.stop;
  assign p_start = ~taken & ~bus.stop & bus.start;
  assign p_tick  = ~taken & ~bus.stop & ~bus.start & bus.tick;

  always_comb begin
    nstate = state;
    ndone  = 1'b0;
    c_clr  = 1'b0;
    c_ld   = 1'b0;
    c_ldv  = bus.load_value;
    c_dec  = 1'b0;
`ifdef TIMER_ADD30_EN
    c_inc  = 1'b0;
`endif
    unique case (1'b1)
      p_clr: begin
        c_clr  = 1'b1;
        nstate = IDLE;
      end
      p_ld: begin
        c_ld   = 1'b1;
        nstate = IDLE;
      end
`ifdef TIMER_ADD30_EN
      p_add: begin
        if (state == DONE || (state == IDLE && is_zero)) begin
          c_ld   = 1'b1;
          c_ldv  = QS_VAL;
          nstate = RUN;
        end else begin
          c_inc  = 1'b1;
        end
      end
`endif
      p_stop: begin
        unique case (state)
          RUN:  nstate = PAUSED;
          DONE: nstate = IDLE;
          default: begin
            c_clr  = 1'b1;
            nstate = IDLE;
          end
        endcase
      end
      p_start: begin
        if ((state == IDLE || state == PAUSED) && !is_zero)
          nstate = RUN;
      end
      p_tick: begin
        if (run_st) begin
          c_dec = 1'b1;
          if (to_zero) begin
            nstate = DONE;
            ndone  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= nstate;
      done_q <= ndone;
    end
  end

  assign borrow[0]     = c_dec;
  assign unused_borrow = borrow[NUM_DIGITS];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell #(
      .IS_MOD6 (MOD6_MASK[i])
    ) u_cell (
      .clk        (clk),
      .clr        (c_clr),
      .load       (c_ld),
      .load_digit (c_ldv[4*i +: 4]),
      .borrow_in  (borrow[i]),
      .borrow_out (borrow[i+1]),
`ifdef TIMER_ADD30_EN
      .inc        (c_inc),
      .sat        (c_sat),
      .inc_amt    ((i == ADD30_DIGIT) ? ADD30_INC : 4'd0),
      .carry_in   (carry[i]),
      .carry_out  (carry[i+1]),
`endif
      .q          (value[4*i +: 4]),
      .digit_zero (dz[i])
    );
  end

  assign bus.bcd_out = value;
  assign bus.running = run_st;
  assign bus.zero    = is_zero;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer (mm:ss, 4 digits).
// Quick-add vectors run only when TIMER_ADD30_EN is defined.
module tb_bcd_countdown_timer;

  logic clk   = 1'b0;
  logic clear = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bcd_countdown_timer_if #(.NUM_DIGITS(4)) bus ();

  bcd_countdown_timer #(
    .NUM_DIGITS (4),
    .MOD6_MASK  (4'b0010)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One edge with the currently driven commands, then drop them.
  task automatic cyc();
    @(posedge clk);
    #1;
    clear          = 1'b0;
    bus.tick       = 1'b0;
    bus.load       = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
`ifdef TIMER_ADD30_EN
    bus.add30      = 1'b0;
`endif
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load       = 1'b1;
    bus.load_value = v;
    cyc();
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    cyc();
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc();
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    cyc();
  endtask

  initial begin
    bus.tick       = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = 16'h0000;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
`ifdef TIMER_ADD30_EN
    bus.add30      = 1'b0;
`endif
    cyc();
    check("rst_bcd", 32'(bus.bcd_out), 32'h0000);
    check("rst_run", 32'(bus.running), 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);

    do_load(16'h0102);
    check("ld0102", 32'(bus.bcd_out), 32'h0102);
    check("ld_idle", 32'(bus.running), 32'd0);
    do_start();
    check("st_run", 32'(bus.running), 32'd1);
    do_tick();
    check("t1", 32'(bus.bcd_out), 32'h0101);
    do_tick();
    check("t2", 32'(bus.bcd_out), 32'h0100);
    do_tick();
    check("t3_borrow", 32'(bus.bcd_out), 32'h0059);
    check("t3_run", 32'(bus.running), 32'd1);

    do_load(16'h1000);
    do_start();
    do_tick();
    check("borrow3", 32'(bus.bcd_out), 32'h0959);

    do_load(16'h0001);
    do_start();
    do_tick();
    check("dn_bcd", 32'(bus.bcd_out), 32'h0000);
    check("dn_zero", 32'(bus.zero), 32'd1);
    check("dn_run", 32'(bus.running), 32'd0);
    check("dn_pulse", 32'(bus.done), 32'd1);
    cyc();
    check("dn_drop", 32'(bus.done), 32'd0);
    for (int i = 0; i < 5; i++) do_tick();
    check("dn_hold", 32'(bus.bcd_out), 32'h0000);
    check("dn_nodone", 32'(bus.done), 32'd0);
    do_stop();
    do_start();
    check("dn_stop_idle", 32'(bus.running), 32'd0);

    do_load(16'h0A7C);
    check("clamp1", 32'(bus.bcd_out), 32'h0959);
    check("clamp_idle", 32'(bus.running), 32'd0);
    do_load(16'hF6F9);
    check("clamp2", 32'(bus.bcd_out), 32'h9659);
    do_stop();
    check("idle_stop0", 32'(bus.bcd_out), 32'h0000);
    do_start();
    check("st_zero_ign", 32'(bus.running), 32'd0);

    do_load(16'h0030);
    do_start();
    do_stop();
    check("pause_run", 32'(bus.running), 32'd0);
    check("pause_bcd", 32'(bus.bcd_out), 32'h0030);
    for (int i = 0; i < 3; i++) do_tick();
    check("pause_tick", 32'(bus.bcd_out), 32'h0030);
    bus.start = 1'b1;
    bus.tick  = 1'b1;
    cyc();
    check("resume_run", 32'(bus.running), 32'd1);
    check("resume_bcd", 32'(bus.bcd_out), 32'h0030);
    do_tick();
    check("resume_t", 32'(bus.bcd_out), 32'h0029);
    do_stop();
    check("stop1", 32'(bus.bcd_out), 32'h0029);
    do_stop();
    check("stop2", 32'(bus.bcd_out), 32'h0000);
    check("stop2_run", 32'(bus.running), 32'd0);

    do_load(16'h0010);
    do_start();
    bus.stop = 1'b1;
    bus.tick = 1'b1;
    cyc();
    check("stoptick_bcd", 32'(bus.bcd_out), 32'h0010);
    check("stoptick_run", 32'(bus.running), 32'd0);
    bus.start = 1'b1;
    bus.load  = 1'b1;
    bus.load_value = 16'h0500;
    cyc();
    check("ldst_bcd", 32'(bus.bcd_out), 32'h0500);
    check("ldst_run", 32'(bus.running), 32'd0);
    clear = 1'b1;
    bus.load = 1'b1;
    bus.load_value = 16'h1234;
    cyc();
    check("clrld", 32'(bus.bcd_out), 32'h0000);

`ifdef TIMER_ADD30_EN
    do_load(16'h0045);
    do_start();
    bus.add30 = 1'b1;
    cyc();
    check("a30_bcd", 32'(bus.bcd_out), 32'h0115);
    check("a30_run", 32'(bus.running), 32'd1);
    do_load(16'h9950);
    bus.add30 = 1'b1;
    cyc();
    check("a30_sat", 32'(bus.bcd_out), 32'h9959);
    check("a30_sat_idle", 32'(bus.running), 32'd0);
    do_stop();
    bus.add30 = 1'b1;
    cyc();
    check("a30_qs_bcd", 32'(bus.bcd_out), 32'h0030);
    check("a30_qs_run", 32'(bus.running), 32'd1);
    do_load(16'h0001);
    do_start();
    do_tick();
    check("a30_dn", 32'(bus.done), 32'd1);
    bus.add30 = 1'b1;
    cyc();
    check("a30_dn_bcd", 32'(bus.bcd_out), 32'h0030);
    check("a30_dn_run", 32'(bus.running), 32'd1);
    check("a30_dn_done", 32'(bus.done), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
